cmd_issuer: RTL and testbench

Upstream command feeder for the n-bit CPU core. It buffers complete operations from a valid/ready source in a small FIFO: a 7-bit command plus three WIDTH-bit operands. It then presents them one at a time on the core's `cmdin`/`din_1..3` inputs. Each command is held stable for a fixed number of cycles and followed by one NOP cycle, which gives the core's command register and control FSM a clean edge per operation.

---
 rtl/cmd_issuer_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/cmd_issuer.sv | 117 +++++++++++
 tb/tb_cmd_issuer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_issuer_pkg.sv
// Shared types and constants for the command issuer: entry layout, FSM states, NOP encoding.
package cmd_issuer_pkg;

  localparam int CMD_W = 7;
  localparam logic [CMD_W-1:0] CMD_NOP = 7'd0;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Entry layout at the default core width; cmd_issuer mirrors this shape for its own WIDTH.
  typedef struct packed {
    logic [CMD_W-1:0]         cmd;
    logic [DEFAULT_WIDTH-1:0] din_1;
    logic [DEFAULT_WIDTH-1:0] din_2;
    logic [DEFAULT_WIDTH-1:0] din_3;
  } cmd_entry_t;

  function automatic int entry_bits(input int width);
    return CMD_W + 3 * width;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count; full/empty derive from the registered count,
// so a same-cycle pop never frees space for a same-cycle push.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cmd_issuer.sv
// Feeds buffered commands to the core: each entry is held for HOLD cycles on cmdin, then one NOP cycle.
// Source handshake: an entry transfers on a rising edge where s_valid && s_ready && !flush.
module cmd_issuer
  import cmd_issuer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int HOLD  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CMD_W-1:0] s_cmd,
  input  logic [WIDTH-1:0] s_din_1,
  input  logic [WIDTH-1:0] s_din_2,
  input  logic [WIDTH-1:0] s_din_3,
  output logic [CMD_W-1:0] cmdin,
  output logic [WIDTH-1:0] din_1,
  output logic [WIDTH-1:0] din_2,
  output logic [WIDTH-1:0] din_3,
  output logic             issue,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output state_t           state
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [WIDTH-1:0] din_1;
    logic [WIDTH-1:0] din_2;
    logic [WIDTH-1:0] din_3;
  } entry_t;

  entry_t            wr_entry;
  entry_t            rd_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              do_pop;
  state_t            next_state;
  logic [HOLD_W-1:0] hold_cnt;

  assign wr_entry = '{cmd: s_cmd, din_1: s_din_1, din_2: s_din_2, din_3: s_din_3};
  assign s_ready  = !fifo_full;
  assign busy     = (state != IDLE);

  sync_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .push    (s_valid),
    .pop     (do_pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // IDLE and GAP behave identically when work is queued; GAP just falls back to IDLE otherwise.
  always_comb begin
    next_state = state;
    do_pop     = 1'b0;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (!fifo_empty) begin
            do_pop     = 1'b1;
            next_state = ISSUE;
          end else begin
            next_state = IDLE;
          end
        end
        ISSUE:   if (hold_cnt == '0) next_state = GAP;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmdin    <= CMD_NOP;
      din_1    <= '0;
      din_2    <= '0;
      din_3    <= '0;
      issue    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      issue <= do_pop;
      if (do_pop) begin
        cmdin    <= rd_entry.cmd;
        din_1    <= rd_entry.din_1;
        din_2    <= rd_entry.din_2;
        din_3    <= rd_entry.din_3;
        hold_cnt <= HOLD_W'(HOLD - 1);
      end else begin
        if (next_state != ISSUE) cmdin <= CMD_NOP;
        if (state == ISSUE && hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed bench for cmd_issuer (WIDTH=8, DEPTH=4, HOLD=4) with an issue-order scoreboard.
module tb_cmd_issuer;
  import cmd_issuer_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             s_valid;
  logic             s_ready;
  logic [6:0]       s_cmd;
  logic [WIDTH-1:0] s_din_1, s_din_2, s_din_3;
  logic [6:0]       cmdin;
  logic [WIDTH-1:0] din_1, din_2, din_3;
  logic             issue;
  logic             busy;
  logic [CNT_W-1:0] count;
  state_t           state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [14:0] exp_q[$];
  logic [6:0]  bb_cmd [14];
  logic [2:0]  bb_cnt [14];

  cmd_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd),
    .s_din_1(s_din_1), .s_din_2(s_din_2), .s_din_3(s_din_3),
    .cmdin(cmdin), .din_1(din_1), .din_2(din_2), .din_3(din_3),
    .issue(issue), .busy(busy), .count(count), .state(state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; every issue pulse is checked against the scoreboard.
  task automatic step();
    logic [14:0] e;
    @(posedge clk);
    #1;
    if (issue) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 15'h7fff;
      chk("sb_order", 32'({cmdin, din_1}), 32'(e));
    end
  endtask

  task automatic offer(input logic [6:0] c, input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    s_valid = 1'b1;
    s_cmd   = c;
    s_din_1 = a;
    s_din_2 = b;
    s_din_3 = d;
    exp_q.push_back({c, a});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (busy || exp_q.size() != 0); i++) step();
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    bb_cmd = '{7'h11, 7'h11, 7'h00, 7'h22, 7'h22, 7'h22, 7'h22, 7'h00,
               7'h33, 7'h33, 7'h33, 7'h33, 7'h00, 7'h00};
    bb_cnt = '{3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
               3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    // Reset held with a valid source: nothing may be pushed
    rst = 1'b1; flush = 1'b0;
    s_valid = 1'b1; s_cmd = 7'h7e; s_din_1 = 8'h11; s_din_2 = 8'h22; s_din_3 = 8'h33;
    repeat (3) step();
    chk("rst_cmdin", 32'(cmdin), 32'd0);
    chk("rst_din_1", 32'(din_1), 32'd0);
    chk("rst_din_2", 32'(din_2), 32'd0);
    chk("rst_din_3", 32'(din_3), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0; s_valid = 1'b0;
    step();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_cmdin", 32'(cmdin), 32'd0);

    // Single command: visible 2 edges after the push, held 4 cycles, then one GAP cycle
    offer(7'h15, 8'h03, 8'h05, 8'h07);
    step();
    s_valid = 1'b0;
    chk("single_push_count", 32'(count), 32'd1);
    chk("single_no_bypass", 32'(cmdin), 32'd0);
    step();
    chk("single_cmdin", 32'(cmdin), 32'h15);
    chk("single_din_1", 32'(din_1), 32'h03);
    chk("single_din_2", 32'(din_2), 32'h05);
    chk("single_din_3", 32'(din_3), 32'h07);
    chk("single_issue", 32'(issue), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_pop_count", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_hold_cmdin", 32'(cmdin), 32'h15);
      chk("single_hold_issue", 32'(issue), 32'd0);
    end
    step();
    chk("single_gap_cmdin", 32'(cmdin), 32'd0);
    chk("single_gap_busy", 32'(busy), 32'd1);
    chk("single_gap_state", 32'(state), 32'(GAP));
    chk("single_gap_din_1", 32'(din_1), 32'h03);
    step();
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_state", 32'(state), 32'(IDLE));
    chk("single_idle_din_3", 32'(din_3), 32'h07);

    // Back-to-back: A x4, 0, B x4, 0, C x4, 0
    offer(7'h11, 8'ha1, 8'ha2, 8'ha3);
    step();
    chk("b2b_count_a", 32'(count), 32'd1);
    offer(7'h22, 8'hb1, 8'hb2, 8'hb3);
    step();
    chk("b2b_pushpop_count", 32'(count), 32'd1);
    chk("b2b_first_cmdin", 32'(cmdin), 32'h11);
    offer(7'h33, 8'hc1, 8'hc2, 8'hc3);
    step();
    s_valid = 1'b0;
    chk("b2b_count_c", 32'(count), 32'd2);
    chk("b2b_cmdin_e3", 32'(cmdin), 32'h11);
    for (int i = 0; i < 14; i++) begin
      step();
      chk("b2b_cmdin", 32'(cmdin), 32'(bb_cmd[i]));
      chk("b2b_count", 32'(count), 32'(bb_cnt[i]));
    end
    chk("b2b_end_busy", 32'(busy), 32'd0);

    // Full FIFO: the sixth offer waits for a pop, nothing lost or duplicated
    offer(7'h41, 8'h01, 8'h10, 8'h20);
    step();
    chk("full_count_1", 32'(count), 32'd1);
    offer(7'h42, 8'h02, 8'h11, 8'h21);
    step();
    chk("full_count_2", 32'(count), 32'd1);
    offer(7'h43, 8'h03, 8'h12, 8'h22);
    step();
    chk("full_count_3", 32'(count), 32'd2);
    offer(7'h44, 8'h04, 8'h13, 8'h23);
    step();
    chk("full_count_4", 32'(count), 32'd3);
    chk("full_ready_3", 32'(s_ready), 32'd1);
    offer(7'h45, 8'h05, 8'h14, 8'h24);
    step();
    chk("full_count_5", 32'(count), 32'd4);
    chk("full_ready_low", 32'(s_ready), 32'd0);
    offer(7'h46, 8'h06, 8'h15, 8'h25);
    step();
    chk("full_blocked_count", 32'(count), 32'd4);
    chk("full_blocked_ready", 32'(s_ready), 32'd0);
    step();
    chk("full_after_pop_count", 32'(count), 32'd3);
    chk("full_after_pop_ready", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    chk("full_refill_count", 32'(count), 32'd4);
    chk("full_refill_ready", 32'(s_ready), 32'd0);
    drain("full");

    // Flush mid-ISSUE with three entries queued
    offer(7'h51, 8'h91, 8'h92, 8'h93);
    step();
    offer(7'h52, 8'h94, 8'h95, 8'h96);
    step();
    offer(7'h53, 8'h97, 8'h98, 8'h99);
    step();
    offer(7'h54, 8'h9a, 8'h9b, 8'h9c);
    step();
    chk("flush_pre_count", 32'(count), 32'd3);
    chk("flush_pre_cmdin", 32'(cmdin), 32'h51);
    flush = 1'b1;
    s_valid = 1'b1; s_cmd = 7'h55; s_din_1 = 8'hee;
    exp_q.delete();
    step();
    chk("flush_cmdin", 32'(cmdin), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_state", 32'(state), 32'(IDLE));
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_din_1", 32'(din_1), 32'h91);
    chk("flush_din_3", 32'(din_3), 32'h93);
    chk("flush_s_ready", 32'(s_ready), 32'd1);
    flush = 1'b0; s_valid = 1'b0;
    step();
    chk("flush_dropped_push", 32'(count), 32'd0);
    chk("flush_quiet_cmdin", 32'(cmdin), 32'd0);
    offer(7'h5a, 8'h77, 8'h78, 8'h79);
    step();
    s_valid = 1'b0;
    chk("flush_repush_count", 32'(count), 32'd1);
    step();
    chk("flush_reissue_cmdin", 32'(cmdin), 32'h5a);
    chk("flush_reissue_din_2", 32'(din_2), 32'h78);
    chk("flush_reissue_issue", 32'(issue), 32'd1);
    drain("flush");

    // Simultaneous push and pop at count = 1 keeps count and order
    offer(7'h61, 8'h81, 8'h82, 8'h83);
    step();
    chk("pp_count_before", 32'(count), 32'd1);
    offer(7'h62, 8'h84, 8'h85, 8'h86);
    step();
    s_valid = 1'b0;
    chk("pp_count_same", 32'(count), 32'd1);
    chk("pp_first_cmdin", 32'(cmdin), 32'h61);
    drain("pp");

    // Reset asserted mid-ISSUE clears everything at the next edge
    offer(7'h70, 8'h44, 8'h45, 8'h46);
    step();
    s_valid = 1'b0;
    step();
    chk("mid_rst_pre_cmdin", 32'(cmdin), 32'h70);
    rst = 1'b1;
    step();
    chk("mid_rst_cmdin", 32'(cmdin), 32'd0);
    chk("mid_rst_din_1", 32'(din_1), 32'd0);
    chk("mid_rst_state", 32'(state), 32'(IDLE));
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    step();
    chk("mid_rst_after_cmdin", 32'(cmdin), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
